alu_issue_scheduler: RTL and testbench
======================================

ALU_ISSUE_SCHEDULER -- requirements
Module: alu_issue_scheduler

Interface
REQ-001 Parameter NUM_REG, default 32: physical register count; PW = $clog2(NUM_REG).
REQ-002 Parameter DEPTH, default 8: issue queue entries; CW = $clog2(DEPTH+1).
REQ-003 Parameter OP_W, default 4: alu_op width; IMM_W, default 8: immediate width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 n_rst  in  1  reset; synchronous and active-high (1 = reset).
REQ-006 flush  in  1  discard all queued entries.
REQ-007 disp_valid  in  1  dispatch request from rename stage.
REQ-008 disp_ready  out  1  queue can accept a dispatch.
REQ-009 disp_ra, disp_rt, disp_rd  in  PW each  source A, source T, destination physical regs.
REQ-010 disp_ra_rdy, disp_rt_rdy  in  1 each  source already written at dispatch.
REQ-011 disp_use_rt  in  1  op1 is rt (1) or immediate (0).
REQ-012 disp_immdt  in  IMM_W  immediate; disp_alu_op  in  OP_W  ALU opcode.
REQ-013 wb_valid  in  1  writeback broadcast; wb_preg  in  PW  register written.
REQ-014 iss_valid  out  1  an entry is offered to the ALU path.
REQ-015 iss_ready  in  1  ALU path accepts the offered entry.
REQ-016 iss_ra, iss_rt, iss_rd  out  PW; iss_use_rt  out  1; iss_immdt  out  IMM_W; iss_alu_op  out  OP_W: fields of offered entry.
REQ-017 count  out  CW  number of valid entries.

Function
REQ-018 Queue is collapsing: entry 0 oldest; valid entries always occupy indices 0..count-1 contiguously.
REQ-019 Entry stores ra, rt, rd, use_rt, immdt, alu_op, ra_rdy, rt_rdy.
REQ-020 Entry eligible when ra_rdy=1 and (rt_rdy=1 or use_rt=0), evaluated from registered state only.
REQ-021 iss_valid=1 iff some valid entry is eligible and flush=0; selected entry is lowest-index eligible one; iss_* show its fields (combinational from registers, no cycle latency).
REQ-022 Issue fires when iss_valid & iss_ready; selected entry removed at edge, higher entries shift down by one.
REQ-023 iss_* fields held stable while iss_valid=1 and iss_ready=0 unless an older entry becomes eligible.
REQ-024 disp_ready = (count < DEPTH), registered-state only; no dependence on iss_ready in same cycle.
REQ-025 Dispatch fires when disp_valid & disp_ready & !flush; new entry written at index count (count-1 if issue fires same cycle).
REQ-026 Minimum dispatch-to-issue latency one cycle: entry dispatched at edge N may issue in cycle after edge N.
REQ-027 Wakeup: when wb_valid=1, every valid entry with ra==wb_preg sets ra_rdy, rt==wb_preg sets rt_rdy, at the edge.
REQ-028 Same-cycle dispatch and wakeup: incoming disp_ra/disp_rt matching wb_preg stored ready.
REQ-029 Wakeup affecting the entry issuing that cycle is ignored (entry leaves).
REQ-030 Simultaneous dispatch + issue: count unchanged; ordering preserved.
REQ-031 count increments on dispatch only, decrements on issue only; never exceeds DEPTH or underflows.
REQ-032 flush has priority: iss_valid forced 0 that cycle, dispatch ignored, all entries invalidated and count=0 at edge.
REQ-033 Invalid entry fields are don't-care; iss_* don't-care when iss_valid=0.

Reset
REQ-034 n_rst=1 at edge: all entries invalid, count=0; at next cycle disp_ready=1, iss_valid=0.
REQ-035 Reset overrides flush, dispatch, issue and wakeup in same cycle; mid-operation reset discards all entries.
REQ-036 No output is X after first reset edge.

Verification
REQ-037 Reset, then dispatch ra=3 rdy, use_rt=0, rd=5 -> next cycle iss_valid=1, iss_rd=5, count=1; iss_ready=1 -> count=0, iss_valid=0.
REQ-038 Dispatch A (ra=4 not rdy), then B (ready) -> B issues first; wb_preg=4 -> A eligible next cycle, issues.
REQ-039 Fill 8 entries with iss_ready=0 -> count=8, disp_ready=0; dispatch held, not accepted; one issue -> disp_ready=1 next cycle.
REQ-040 Dispatch disp_rt=9 unready, use_rt=1, with wb_valid=1, wb_preg=9 same cycle -> entry eligible next cycle.
REQ-041 Count=5 with dispatch and flush same cycle -> iss_valid=0 that cycle, count=0 after edge.
REQ-042 Count=6, assert n_rst mid-stream with dispatch+issue active -> count=0, iss_valid=0, disp_ready=1 after edge.

Source files
------------

// File: rtl/alu_issue_scheduler.sv
// rtl/alu_issue_scheduler.sv - collapsing in-order-priority ALU issue queue with writeback wakeup
module alu_issue_scheduler #(
    parameter int NUM_REG = 32,
    parameter int DEPTH   = 8,
    parameter int OP_W    = 4,
    parameter int IMM_W   = 8,
    localparam int PW     = $clog2(NUM_REG),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [PW-1:0]    disp_ra,
    input  logic [PW-1:0]    disp_rt,
    input  logic [PW-1:0]    disp_rd,
    input  logic             disp_ra_rdy,
    input  logic             disp_rt_rdy,
    input  logic             disp_use_rt,
    input  logic [IMM_W-1:0] disp_immdt,
    input  logic [OP_W-1:0]  disp_alu_op,
    input  logic             wb_valid,
    input  logic [PW-1:0]    wb_preg,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [PW-1:0]    iss_ra,
    output logic [PW-1:0]    iss_rt,
    output logic [PW-1:0]    iss_rd,
    output logic             iss_use_rt,
    output logic [IMM_W-1:0] iss_immdt,
    output logic [OP_W-1:0]  iss_alu_op,
    output logic [CW-1:0]    count
);

    // Entry storage; index 0 is the oldest, valid entries are 0..count-1.
    logic [PW-1:0]    q_ra     [DEPTH];
    logic [PW-1:0]    q_rt     [DEPTH];
    logic [PW-1:0]    q_rd     [DEPTH];
    logic [IMM_W-1:0] q_immdt  [DEPTH];
    logic [OP_W-1:0]  q_alu_op [DEPTH];
    logic [DEPTH-1:0] q_use_rt;
    logic [DEPTH-1:0] q_ra_rdy;
    logic [DEPTH-1:0] q_rt_rdy;

    logic [PW-1:0]    n_ra     [DEPTH];
    logic [PW-1:0]    n_rt     [DEPTH];
    logic [PW-1:0]    n_rd     [DEPTH];
    logic [IMM_W-1:0] n_immdt  [DEPTH];
    logic [OP_W-1:0]  n_alu_op [DEPTH];
    logic [DEPTH-1:0] n_use_rt;
    logic [DEPTH-1:0] n_ra_rdy;
    logic [DEPTH-1:0] n_rt_rdy;
    logic [CW-1:0]    n_count;

    logic [DEPTH-1:0] elig;
    logic             any_elig;
    logic [CW-1:0]    sel_idx;
    logic [CW-1:0]    wr_idx;
    logic             iss_fire;
    logic             disp_fire;

    // Full check looks only at the registered count, so dispatch never waits on iss_ready.
    assign disp_ready = (count < CW'(DEPTH));
    assign iss_valid  = any_elig && !flush;
    assign iss_fire   = iss_valid && iss_ready;
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign wr_idx     = count - {{(CW-1){1'b0}}, iss_fire};

    // Pick the oldest eligible entry and present its fields.
    always_comb begin
        elig       = '0;
        any_elig   = 1'b0;
        sel_idx    = '0;
        iss_ra     = '0;
        iss_rt     = '0;
        iss_rd     = '0;
        iss_use_rt = 1'b0;
        iss_immdt  = '0;
        iss_alu_op = '0;
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = (CW'(i) < count) && q_ra_rdy[i] && (q_rt_rdy[i] || !q_use_rt[i]);
            if (elig[i] && !any_elig) begin
                any_elig   = 1'b1;
                sel_idx    = CW'(i);
                iss_ra     = q_ra[i];
                iss_rt     = q_rt[i];
                iss_rd     = q_rd[i];
                iss_use_rt = q_use_rt[i];
                iss_immdt  = q_immdt[i];
                iss_alu_op = q_alu_op[i];
            end
        end
    end

    // Build the next queue image: collapse over the issued slot, apply wakeup, append dispatch.
    always_comb begin
        n_ra     = q_ra;
        n_rt     = q_rt;
        n_rd     = q_rd;
        n_immdt  = q_immdt;
        n_alu_op = q_alu_op;
        n_use_rt = q_use_rt;
        n_ra_rdy = q_ra_rdy;
        n_rt_rdy = q_rt_rdy;
        n_count  = count;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (iss_fire && (CW'(i) >= sel_idx)) begin
                n_ra[i]     = q_ra[i+1];
                n_rt[i]     = q_rt[i+1];
                n_rd[i]     = q_rd[i+1];
                n_immdt[i]  = q_immdt[i+1];
                n_alu_op[i] = q_alu_op[i+1];
                n_use_rt[i] = q_use_rt[i+1];
                n_ra_rdy[i] = q_ra_rdy[i+1];
                n_rt_rdy[i] = q_rt_rdy[i+1];
            end
        end
        // The issued entry has already shifted out, so its wakeup is naturally dropped.
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_valid && (n_ra[i] == wb_preg)) begin
                n_ra_rdy[i] = 1'b1;
            end
            if (wb_valid && (n_rt[i] == wb_preg)) begin
                n_rt_rdy[i] = 1'b1;
            end
            if (disp_fire && (CW'(i) == wr_idx)) begin
                n_ra[i]     = disp_ra;
                n_rt[i]     = disp_rt;
                n_rd[i]     = disp_rd;
                n_immdt[i]  = disp_immdt;
                n_alu_op[i] = disp_alu_op;
                n_use_rt[i] = disp_use_rt;
                n_ra_rdy[i] = disp_ra_rdy || (wb_valid && (disp_ra == wb_preg));
                n_rt_rdy[i] = disp_rt_rdy || (wb_valid && (disp_rt == wb_preg));
            end
        end
        if (flush) begin
            n_count = '0;
        end else begin
            n_count = count + CW'(disp_fire) - CW'(iss_fire);
        end
    end

    // Queue state register; reset clears every field so no output is ever unknown.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            count    <= '0;
            q_use_rt <= '0;
            q_ra_rdy <= '0;
            q_rt_rdy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_ra[i]     <= '0;
                q_rt[i]     <= '0;
                q_rd[i]     <= '0;
                q_immdt[i]  <= '0;
                q_alu_op[i] <= '0;
            end
        end else begin
            count    <= n_count;
            q_ra     <= n_ra;
            q_rt     <= n_rt;
            q_rd     <= n_rd;
            q_immdt  <= n_immdt;
            q_alu_op <= n_alu_op;
            q_use_rt <= n_use_rt;
            q_ra_rdy <= n_ra_rdy;
            q_rt_rdy <= n_rt_rdy;
        end
    end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// tb/tb_alu_issue_scheduler.sv - scoreboard bench for alu_issue_scheduler
module tb_alu_issue_scheduler;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       flush;
    logic       disp_valid;
    logic       disp_ready;
    logic [4:0] disp_ra, disp_rt, disp_rd;
    logic       disp_ra_rdy, disp_rt_rdy, disp_use_rt;
    logic [7:0] disp_immdt;
    logic [3:0] disp_alu_op;
    logic       wb_valid;
    logic [4:0] wb_preg;
    logic       iss_valid;
    logic       iss_ready;
    logic [4:0] iss_ra, iss_rt, iss_rd;
    logic       iss_use_rt;
    logic [7:0] iss_immdt;
    logic [3:0] iss_alu_op;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;
    logic [27:0] sb_q[$];

    alu_issue_scheduler dut (
        .clk(clk), .n_rst(n_rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_ra(disp_ra), .disp_rt(disp_rt), .disp_rd(disp_rd),
        .disp_ra_rdy(disp_ra_rdy), .disp_rt_rdy(disp_rt_rdy), .disp_use_rt(disp_use_rt),
        .disp_immdt(disp_immdt), .disp_alu_op(disp_alu_op),
        .wb_valid(wb_valid), .wb_preg(wb_preg),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_ra(iss_ra), .iss_rt(iss_rt), .iss_rd(iss_rd),
        .iss_use_rt(iss_use_rt), .iss_immdt(iss_immdt), .iss_alu_op(iss_alu_op),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] pack(input logic [4:0] rd, input logic [4:0] ra,
                                         input logic [4:0] rt, input logic use_rt,
                                         input logic [7:0] imm, input logic [3:0] op);
        return {rd, ra, rt, use_rt, imm, op};
    endfunction

    // Every issue handshake seen away from the edge is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!n_rst && iss_valid && iss_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_issue", {27'd0, iss_rd}, 32'hFFFF_FFFF);
            end else begin
                check("issue_fields",
                      {4'd0, pack(iss_rd, iss_ra, iss_rt, iss_use_rt, iss_immdt, iss_alu_op)},
                      {4'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [4:0] ra, input logic [4:0] rt, input logic [4:0] rd,
                            input logic ra_rdy, input logic rt_rdy, input logic use_rt,
                            input logic [7:0] imm, input logic [3:0] op);
        disp_ra = ra; disp_rt = rt; disp_rd = rd;
        disp_ra_rdy = ra_rdy; disp_rt_rdy = rt_rdy; disp_use_rt = use_rt;
        disp_immdt = imm; disp_alu_op = op;
        disp_valid = 1'b1;
        tick();
        disp_valid = 1'b0;
    endtask

    initial begin
        n_rst = 1'b1; flush = 1'b0; disp_valid = 1'b0;
        disp_ra = '0; disp_rt = '0; disp_rd = '0;
        disp_ra_rdy = 1'b0; disp_rt_rdy = 1'b0; disp_use_rt = 1'b0;
        disp_immdt = '0; disp_alu_op = '0;
        wb_valid = 1'b0; wb_preg = '0; iss_ready = 1'b0;
        tick(); tick();
        n_rst = 1'b0;
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
        check("rst_disp_ready", {31'd0, disp_ready}, 32'd1);

        // Single ready op issues one cycle after dispatch.
        sb_q.push_back(pack(5'd5, 5'd3, 5'd0, 1'b0, 8'h11, 4'd2));
        dispatch(5'd3, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 8'h11, 4'd2);
        check("t1_iss_valid", {31'd0, iss_valid}, 32'd1);
        check("t1_iss_rd", {27'd0, iss_rd}, 32'd5);
        check("t1_count", {28'd0, count}, 32'd1);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        check("t1_count_after", {28'd0, count}, 32'd0);
        check("t1_iss_valid_after", {31'd0, iss_valid}, 32'd0);

        // Younger ready op bypasses an older waiting one; wakeup releases the older.
        dispatch(5'd4, 5'd0, 5'd10, 1'b0, 1'b0, 1'b0, 8'h22, 4'd3);
        check("t2_a_blocked", {31'd0, iss_valid}, 32'd0);
        sb_q.push_back(pack(5'd11, 5'd6, 5'd0, 1'b0, 8'h33, 4'd4));
        sb_q.push_back(pack(5'd10, 5'd4, 5'd0, 1'b0, 8'h22, 4'd3));
        dispatch(5'd6, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 8'h33, 4'd4);
        check("t2_b_first", {27'd0, iss_rd}, 32'd11);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        check("t2_a_still_blocked", {31'd0, iss_valid}, 32'd0);
        wb_valid = 1'b1; wb_preg = 5'd4;
        tick();
        wb_valid = 1'b0;
        check("t2_a_woken", {31'd0, iss_valid}, 32'd1);
        check("t2_a_rd", {27'd0, iss_rd}, 32'd10);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        check("t2_count", {28'd0, count}, 32'd0);

        // Fill to capacity, hold a dispatch against back-pressure, then issue and drain.
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(pack(5'(20 + i), 5'(i), 5'd0, 1'b0, 8'(i * 3), 4'(i)));
            dispatch(5'(i), 5'd0, 5'(20 + i), 1'b1, 1'b0, 1'b0, 8'(i * 3), 4'(i));
        end
        check("t3_full_count", {28'd0, count}, 32'd8);
        check("t3_full_ready", {31'd0, disp_ready}, 32'd0);
        check("t3_oldest_held", {27'd0, iss_rd}, 32'd20);
        disp_rd = 5'd31; disp_ra = 5'd1; disp_ra_rdy = 1'b1; disp_valid = 1'b1;
        tick(); tick();
        disp_valid = 1'b0;
        check("t3_held_count", {28'd0, count}, 32'd8);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        check("t3_ready_again", {31'd0, disp_ready}, 32'd1);
        check("t3_count7", {28'd0, count}, 32'd7);
        sb_q.push_back(pack(5'd28, 5'd9, 5'd0, 1'b0, 8'h44, 4'd9));
        iss_ready = 1'b1;
        dispatch(5'd9, 5'd0, 5'd28, 1'b1, 1'b0, 1'b0, 8'h44, 4'd9);
        check("t3_disp_iss_count", {28'd0, count}, 32'd7);
        for (int i = 0; i < 7; i++) tick();
        iss_ready = 1'b0;
        check("t3_drained", {28'd0, count}, 32'd0);

        // Same-cycle wakeup of an incoming rt, then wakeup of a queued rt.
        sb_q.push_back(pack(5'd12, 5'd1, 5'd9, 1'b1, 8'h55, 4'd5));
        wb_valid = 1'b1; wb_preg = 5'd9;
        dispatch(5'd1, 5'd9, 5'd12, 1'b1, 1'b0, 1'b1, 8'h55, 4'd5);
        wb_valid = 1'b0;
        check("t4_bypass_wakeup", {31'd0, iss_valid}, 32'd1);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        sb_q.push_back(pack(5'd14, 5'd2, 5'd13, 1'b1, 8'h66, 4'd6));
        dispatch(5'd2, 5'd13, 5'd14, 1'b1, 1'b0, 1'b1, 8'h66, 4'd6);
        check("t4_rt_blocked", {31'd0, iss_valid}, 32'd0);
        wb_valid = 1'b1; wb_preg = 5'd13;
        tick();
        wb_valid = 1'b0;
        check("t4_rt_woken", {31'd0, iss_valid}, 32'd1);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        check("t4_count", {28'd0, count}, 32'd0);

        // Flush wins over a concurrent dispatch and suppresses issue.
        for (int i = 0; i < 5; i++) begin
            dispatch(5'd15, 5'd0, 5'(i), 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        end
        check("t5_count5", {28'd0, count}, 32'd5);
        wb_valid = 1'b1; wb_preg = 5'd15;
        tick();
        wb_valid = 1'b0;
        disp_ra = 5'd1; disp_ra_rdy = 1'b1; disp_rd = 5'd7; disp_valid = 1'b1;
        flush = 1'b1; iss_ready = 1'b1;
        #1;
        check("t5_flush_iss_valid", {31'd0, iss_valid}, 32'd0);
        tick();
        flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
        check("t5_flush_count", {28'd0, count}, 32'd0);
        check("t5_flush_empty", {31'd0, iss_valid}, 32'd0);

        // Reset mid-stream with dispatch and issue active discards everything.
        for (int i = 0; i < 6; i++) begin
            dispatch(5'd3, 5'd0, 5'(i), 1'b1, 1'b0, 1'b0, 8'd1, 4'd1);
        end
        check("t6_count6", {28'd0, count}, 32'd6);
        n_rst = 1'b1; iss_ready = 1'b1;
        disp_ra = 5'd3; disp_ra_rdy = 1'b1; disp_rd = 5'd30; disp_valid = 1'b1;
        tick();
        n_rst = 1'b0; iss_ready = 1'b0; disp_valid = 1'b0;
        sb_q.delete();
        check("t6_count", {28'd0, count}, 32'd0);
        check("t6_iss_valid", {31'd0, iss_valid}, 32'd0);
        check("t6_disp_ready", {31'd0, disp_ready}, 32'd1);
        tick();
        check("sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
